// File: rtl/sub16_serial.sv
// sub16_serial: 16-bit subtractor computing A - B - Bin one nibble per clock.
// The operands and the borrow-in are captured when a start is accepted. The
// nibbles are processed on the next four rising edges, and the result
// registers change only on the edge that processes the last nibble.
// Optional feature: define SUB16_SAT_EN to saturate Diff on signed overflow.
module sub16_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] Diff,
    output logic        Ovfl,
    output logic        Bout,
    output logic        Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        borrow_q;
    logic [11:0] acc_q;

    logic        accept;
    logic        last_nib;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [4:0]  nib_res;
    logic [15:0] raw_diff;
    logic        ovfl_c;
    logic [15:0] final_diff;

    // A start is taken in any state other than RUN.
    assign accept   = start && (state != RUN);
    assign last_nib = (state == RUN) && (cnt == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> RUN -> (4 nibbles) -> DONE -> IDLE or RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == 2'd3) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Select the current nibble and subtract it with the running borrow.
    always_comb begin
        a_nib = a_q[3:0];
        b_nib = b_q[3:0];
        case (cnt)
            2'd0: begin
                a_nib = a_q[3:0];
                b_nib = b_q[3:0];
            end
            2'd1: begin
                a_nib = a_q[7:4];
                b_nib = b_q[7:4];
            end
            2'd2: begin
                a_nib = a_q[11:8];
                b_nib = b_q[11:8];
            end
            default: begin
                a_nib = a_q[15:12];
                b_nib = b_q[15:12];
            end
        endcase
        nib_res = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
    end

    // Assemble the full result for use on the last-nibble edge.
    always_comb begin
        raw_diff = {nib_res[3:0], acc_q};
        ovfl_c   = (a_q[15] != b_q[15]) && (raw_diff[15] != a_q[15]);
`ifdef SUB16_SAT_EN
        if (ovfl_c) begin
            final_diff = a_q[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            final_diff = raw_diff;
        end
`else
        final_diff = raw_diff;
`endif
    end

    // Datapath. Operand capture, nibble accumulation and result registers.
    // The latched Bin is loaded into the borrow register, so nibble 0 uses
    // the same borrow path as the later nibbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            acc_q    <= '0;
            Diff     <= '0;
            Ovfl     <= 1'b0;
            Bout     <= 1'b0;
            Zero     <= 1'b0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt      <= '0;
        end else if (state == RUN) begin
            borrow_q <= nib_res[4];
            cnt      <= cnt + 2'd1;
            case (cnt)
                2'd0:    acc_q[3:0]  <= nib_res[3:0];
                2'd1:    acc_q[7:4]  <= nib_res[3:0];
                2'd2:    acc_q[11:8] <= nib_res[3:0];
                default: acc_q       <= acc_q;
            endcase
            if (last_nib) begin
                Diff <= final_diff;
                Ovfl <= ovfl_c;
                Bout <= nib_res[4];
                Zero <= (final_diff == 16'h0000);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: randomized and directed self-checking bench for sub16_serial.
// The expected values come from whole-word integer arithmetic. The bench does
// not reproduce the nibble-serial datapath.
`timescale 1ns/1ps
module tb_sub16_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Ovfl;
    logic        Bout;
    logic        Zero;

    int tests_run;
    int tests_failed;

    sub16_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Ovfl  (Ovfl),
        .Bout  (Bout),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Returns {Ovfl, Bout, Zero, Diff}.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
        int          ia;
        int          ib;
        int          res;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        ia  = int'(a);
        ib  = int'(b);
        res = ia - ib - int'(bin);
        d   = 16'(res);
        bo  = (ia < ib + int'(bin));
        ov  = (a[15] != b[15]) && (d[15] != a[15]);
`ifdef SUB16_SAT_EN
        if (ov) d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {ov, bo, (d == 16'h0000), d};
    endfunction

    // Drive one operation and wait (bounded) for done. This task does not compare.
    // lat holds the number of edges from the accept edge to done, or -1 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output int lat);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #12;
        tests_run++;
        if ({busy, done, Diff, Ovfl, Bout, Zero} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b Diff=%h O=%b B=%b Z=%b, need all 0",
                     busy, done, Diff, Ovfl, Bout, Zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vbin [4];
        logic [18:0] e;
        int          lat;
        va[0] = 16'h0005; vb[0] = 16'h0003; vbin[0] = 1'b0;
        va[1] = 16'h0000; vb[1] = 16'h0001; vbin[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h0001; vbin[2] = 1'b0;
        va[3] = 16'h1234; vb[3] = 16'h1233; vbin[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = model(va[k], vb[k], vbin[k]);
            do_op(va[k], vb[k], vbin[k], lat);
            tests_run++;
            if (lat !== 4) begin
                tests_failed++;
                $display("FAIL dir%0d_latency: got %0d, need 4", k, lat);
            end
            tests_run++;
            if ({Ovfl, Bout, Zero, Diff} !== e) begin
                tests_failed++;
                $display("FAIL dir%0d_result: got O=%b B=%b Z=%b D=%h, need O=%b B=%b Z=%b D=%h",
                         k, Ovfl, Bout, Zero, Diff, e[18], e[17], e[16], e[15:0]);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || {Ovfl, Bout, Zero, Diff} !== e) begin
                tests_failed++;
                $display("FAIL dir%0d_hold: got done=%b busy=%b D=%h, need done=0 busy=0 D=%h",
                         k, done, busy, Diff, e[15:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [18:0] e;
        int          lat;
        for (int k = 0; k < 40; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b = a - 16'(bin);
            e = model(a, b, bin);
            do_op(a, b, bin, lat);
            tests_run++;
            if (lat !== 4 || {Ovfl, Bout, Zero, Diff} !== e) begin
                tests_failed++;
                $display("FAIL rand%0d: A=%h B=%h Bin=%b got lat=%0d O=%b B=%b Z=%b D=%h, need lat=4 O=%b B=%b Z=%b D=%h",
                         k, a, b, bin, lat, Ovfl, Bout, Zero, Diff, e[18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_start_during_run();
        logic [18:0] e;
        int          lat;
        e = model(16'h4321, 16'h0123, 1'b0);
        @(negedge clk);
        A = 16'h4321; B = 16'h0123; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_busy: got %b, need 1", busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        A = 16'hFFFF; B = 16'h7777; Bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        tests_run++;
        if (lat !== 4 || {Ovfl, Bout, Zero, Diff} !== e) begin
            tests_failed++;
            $display("FAIL start_in_run: got lat=%0d D=%h O=%b B=%b, need lat=4 D=%h O=%b B=%b",
                     lat, Diff, Ovfl, Bout, e[15:0], e[18], e[17]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_in_run_idle: got busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [18:0] e;
        int          lat;
        int          seen;
        do_op(16'h0000, 16'h0001, 1'b0, lat);
        @(negedge clk);
        A = 16'h0F0F; B = 16'h1234; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, Diff, Ovfl, Bout, Zero} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got busy=%b done=%b D=%h O=%b B=%b Z=%b, need all 0",
                     busy, done, Diff, Ovfl, Bout, Zero);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d done cycles, need 0", seen);
        end
        e = model(16'h0100, 16'h0200, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; A = 16'h0100; B = 16'h0200; Bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_edge_accept: got busy=%b, need 1", busy);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        tests_run++;
        if (lat !== 4 || {Ovfl, Bout, Zero, Diff} !== e) begin
            tests_failed++;
            $display("FAIL after_reset_op: got lat=%0d D=%h B=%b, need lat=4 D=%h B=%b",
                     lat, Diff, Bout, e[15:0], e[17]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [7];
        logic [15:0] qb [7];
        logic        qbin [7];
        logic [18:0] e;
        int          nres;
        for (int k = 0; k < 7; k++) begin
            qa[k] = 16'($urandom); qb[k] = 16'($urandom); qbin[k] = 1'($urandom);
        end
        @(negedge clk);
        A = qa[0]; B = qb[0]; Bin = qbin[0]; start = 1'b1;
        @(posedge clk); #1;
        A = qa[1]; B = qb[1]; Bin = qbin[1];
        nres = 0;
        for (int ed = 1; ed <= 30; ed++) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== (ed % 5 == 4) || busy !== (ed % 5 != 4)) begin
                tests_failed++;
                $display("FAIL b2b_timing edge %0d: got done=%b busy=%b, need done=%b busy=%b",
                         ed, done, busy, (ed % 5 == 4), (ed % 5 != 4));
            end
            if (ed % 5 == 4) begin
                e = model(qa[ed / 5], qb[ed / 5], qbin[ed / 5]);
                nres++;
                tests_run++;
                if ({Ovfl, Bout, Zero, Diff} !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_result%0d: got O=%b B=%b Z=%b D=%h, need O=%b B=%b Z=%b D=%h",
                             ed / 5, Ovfl, Bout, Zero, Diff, e[18], e[17], e[16], e[15:0]);
                end
            end
            if (ed % 5 == 0 && (ed / 5 + 1) < 7) begin
                A = qa[ed / 5 + 1]; B = qb[ed / 5 + 1]; Bin = qbin[ed / 5 + 1];
            end
        end
        start = 1'b0;
        tests_run++;
        if (nres !== 6) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, need 6", nres);
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
